e_mdu_ctrl: RTL

E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_arith.sv | 53 +++++
 rtl/e_mdu_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: opcode and state encodings, default latencies, counter width.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_MSUB  = 3'd7
    } mdu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 8;

    function automatic logic is_multicycle(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) ||
               (op == MDU_DIVU) || (op == MDU_MSUB);
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit {HI,LO} result and write enable for the latched op.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_e     op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o,
    output logic        wr_o
);

    logic signed [63:0] sa, sb, prod_s;
    logic        [63:0] ua, ub, prod_u;
    logic signed [31:0] q_s, r_s;

    always_comb begin
        sa     = {{32{rs_i[31]}}, rs_i};
        sb     = {{32{rt_i[31]}}, rt_i};
        ua     = {32'h0, rs_i};
        ub     = {32'h0, rt_i};
        prod_s = sa * sb;
        prod_u = ua * ub;
        q_s    = '0;
        r_s    = '0;
        res_o  = {hi_i, lo_i};
        wr_o   = 1'b1;
        case (op_i)
            MDU_MULT:  res_o = prod_s;
            MDU_MULTU: res_o = prod_u;
            MDU_MSUB:  res_o = {hi_i, lo_i} - prod_s;
            MDU_DIV: begin
                // The one overflowing quotient is pinned rather than left to the divider.
                if (rt_i == 32'h0) begin
                    wr_o = 1'b0;
                end else if (rs_i == 32'h8000_0000 && rt_i == 32'hFFFF_FFFF) begin
                    res_o = {32'h0, 32'h8000_0000};
                end else begin
                    q_s   = $signed(rs_i) / $signed(rt_i);
                    r_s   = $signed(rs_i) % $signed(rt_i);
                    res_o = {r_s, q_s};
                end
            end
            MDU_DIVU: begin
                if (rt_i == 32'h0) wr_o = 1'b0;
                else               res_o = {rs_i % rt_i, rs_i / rt_i};
            end
            default:   wr_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: accepts one op, holds busy for N cycles, then writes HI/LO.
//   state   | meaning
//   ST_IDLE | accepting ops; MTHI/MTLO write directly
//   ST_RUN  | op in flight, counter counts down to the completion edge
module e_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e       state_q;
    mdu_op_e          op_q;
    logic [31:0]      rs_q, rt_q, hi_q, lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    mdu_op_e          op_in;
    logic [63:0]      res;
    logic             res_wr;

    assign op_in = mdu_op_e'(mdu_op);
    assign start = reset & req_valid & (state_q == ST_IDLE) & is_multicycle(op_in);
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    mdu_arith u_arith (
        .op_i  (op_q),
        .rs_i  (rs_q),
        .rt_i  (rt_q),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .res_o (res),
        .wr_o  (res_wr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_NONE;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        op_q    <= op_in;
                        rs_q    <= rs_val;
                        rt_q    <= rt_val;
                        cnt_q   <= is_div(op_in) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else if (req_valid && op_in == MDU_MTHI) begin
                        hi_q <= rs_val;
                    end else if (req_valid && op_in == MDU_MTLO) begin
                        lo_q <= rs_val;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (res_wr) begin
                            hi_q <= res[63:32];
                            lo_q <= res[31:0];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
